// File: rtl/cpu_defs.sv
// Shared CPU encodings: memory commands, branch modes and fetch-unit states.
package cpu_defs;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic BR_REL = 1'b0;
  localparam logic BR_ABS = 1'b1;

  typedef enum logic [1:0] {
    S_RST   = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/vDFF_w_Load.sv
// Load-enabled register: captures din on a rising edge when load is high.
module vDFF_w_Load #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             load,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] q_d, q_q;

  // Hold unless loading.
  always_comb begin
    q_d = q_q;
    if (load) q_d = din;
  end

  // Storage flop.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign dout = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and memory-address unit: owns PC, IR and the data-address
// register, sequences fetch/execute/halt and drives the single memory port.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic [1:0]        ex_mem_cmd,
  input  logic              ex_addr_load,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic              ex_mem_ready,
  input  logic              ex_done,
  input  logic              br_take,
  input  logic              br_mode,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              halted
);

  fetch_state_e state_d, state_q;

  logic              pc_load, ir_load, dar_load;
  logic [ADDR_W-1:0] pc_in, dar_in, dar;
  logic [DATA_W-1:0] ir_in;

  // Reset is folded into the load path so the plain load registers can be reused.
  vDFF_w_Load #(.Width(ADDR_W)) u_pc_reg (
    .clk  (clk),
    .load (pc_load),
    .din  (pc_in),
    .dout (pc)
  );

  vDFF_w_Load #(.Width(DATA_W)) u_ir_reg (
    .clk  (clk),
    .load (ir_load),
    .din  (ir_in),
    .dout (ir)
  );

  vDFF_w_Load #(.Width(ADDR_W)) u_dar_reg (
    .clk  (clk),
    .load (dar_load),
    .din  (dar_in),
    .dout (dar)
  );

  // State register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Next state plus register load controls; halt outranks a branch at ex_done.
  always_comb begin
    state_d  = state_q;
    pc_load  = 1'b0;
    pc_in    = pc;
    ir_load  = 1'b0;
    ir_in    = mem_rdata;
    dar_load = 1'b0;
    dar_in   = ex_addr;
    if (reset) begin
      state_d  = S_RST;
      pc_load  = 1'b1;
      pc_in    = RESET_PC;
      ir_load  = 1'b1;
      ir_in    = '0;
      dar_load = 1'b1;
      dar_in   = '0;
    end else begin
      unique case (state_q)
        S_RST: state_d = S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            state_d = S_EXEC;
            ir_load = 1'b1;
            pc_load = 1'b1;
            pc_in   = pc + ADDR_W'(1);
          end
        end
        S_EXEC: begin
          dar_load = ex_addr_load;
          if (ex_done) begin
            if (halt) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
              if (br_take) begin
                pc_load = 1'b1;
                // pc already points past this instruction, so REL is relative to pc + 1.
                pc_in   = (br_mode == BR_ABS) ? br_target : pc + br_offset;
              end
            end
          end
        end
        S_HALT: state_d = S_HALT;
      endcase
    end
  end

  // Memory port and status outputs, combinational from state and registers.
  always_comb begin
    mem_cmd      = MNONE;
    mem_addr     = pc;
    ir_valid     = 1'b0;
    ex_mem_ready = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      S_RST: mem_cmd = MNONE;
      S_FETCH: begin
        mem_cmd  = MREAD;
        mem_addr = pc;
      end
      S_EXEC: begin
        ir_valid     = 1'b1;
        mem_addr     = dar;
        ex_mem_ready = mem_ready;
        // Completion suppresses any request; the 2'b11 encoding is not a command.
        if (!ex_done && (ex_mem_cmd != 2'b11)) mem_cmd = ex_mem_cmd;
      end
      S_HALT: halted = 1'b1;
    endcase
  end

  assign link_pc = pc;

endmodule
